sr_mdu: RTL

Iterative multiply/divide unit for the execute stage, alongside `sr_alu`. It takes the same `srcA`/`srcB` operands, computes RV32M `MUL`, `MULHU`, `DIVU` and `REMU` over multiple cycles, and drives a `busy`/`done` handshake that the control unit uses to stall PC and writeback. Its `result` is muxed with the ALU result ahead of the register file write port.

---
 rtl/sr_mdu_if.sv | 15 +
 rtl/sr_mdu.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sr_mdu_if.sv
// Handshake and operand bus between the control/execute stage and sr_mdu.
// master: the execute stage (drives the request, sees busy/done/result).
// slave : the multiply/divide unit.
interface sr_mdu_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, op, srcA, srcB, input busy, done, result);
  modport slave  (input start, op, srcA, srcB, output busy, done, result);
endinterface

// File: rtl/sr_mdu.sv
// sr_mdu: iterative RV32M MUL / MULHU / DIVU / REMU unit, one step per cycle.
// Shift-add multiply and restoring divide share one 32-bit accumulator
// (hi / rem) and one 32-bit shift register (lo / quo); 32 steps per op.
// Optional feature macro: SR_MDU_FASTPATH_EN -- when defined, requests with
// a zero operand skip RUN and complete straight from IDLE.
module sr_mdu (
  input  logic clk,
  input  logic rst_n,
  sr_mdu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  // Multiply keeps the multiplicand here, divide keeps the divisor.
  logic [31:0] opnd_q;
  // acc: hi (multiply) / rem (divide); sh: lo (multiply) / quo (divide).
  logic [31:0] acc_q;
  logic [31:0] sh_q;
  logic [31:0] res_q;

  // Single-step datapath, evaluated every cycle from the current registers.
  logic        is_div;
  logic [32:0] mul_sum;
  logic [31:0] mul_acc, mul_sh;
  logic [32:0] rem_s;
  logic        div_ge;
  logic [31:0] div_acc, div_sh;
  logic [31:0] step_acc, step_sh, step_res;

  assign is_div  = op_q[1];

  // Multiply: add A when lo[0] is set, then shift {sum,lo} right by one.
  assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_acc = mul_sum[32:1];
  assign mul_sh  = {mul_sum[0], sh_q[31:1]};

  // Divide: shift {rem,quo} left, subtract B when it fits. rem stays below B
  // after every step, so a 32-bit accumulator plus the 33-bit shifted view is
  // enough. B=0 always "fits", which yields quo=all ones and rem=A for free.
  assign rem_s   = {acc_q, sh_q[31]};
  assign div_ge  = rem_s >= {1'b0, opnd_q};
  assign div_acc = div_ge ? (rem_s[31:0] - opnd_q) : rem_s[31:0];
  assign div_sh  = {sh_q[30:0], div_ge};

  assign step_acc = is_div ? div_acc : mul_acc;
  assign step_sh  = is_div ? div_sh  : mul_sh;
  // op[0] selects the upper/remainder half for both MULHU and REMU.
  assign step_res = op_q[0] ? step_acc : step_sh;

  // Zero-operand shortcut decode (constant off in the default build).
  logic        fast;
  logic [31:0] fast_res;
`ifdef SR_MDU_FASTPATH_EN
  always_comb begin
    fast     = (bus.srcA == 32'd0) || (bus.srcB == 32'd0);
    fast_res = 32'd0;
    if (bus.op[1] && (bus.srcB == 32'd0))
      fast_res = bus.op[0] ? bus.srcA : 32'hFFFF_FFFF;
  end
`else
  assign fast     = 1'b0;
  assign fast_res = 32'd0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN (or DONE on shortcut) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = fast ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, per-step update and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 5'd0;
      op_q   <= 2'd0;
      opnd_q <= 32'd0;
      acc_q  <= 32'd0;
      sh_q   <= 32'd0;
      res_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          op_q   <= bus.op;
          opnd_q <= bus.op[1] ? bus.srcB : bus.srcA;
          sh_q   <= bus.op[1] ? bus.srcA : bus.srcB;
          acc_q  <= 32'd0;
          cnt_q  <= 5'd0;
          if (fast) res_q <= fast_res;
        end
        S_RUN: begin
          acc_q <= step_acc;
          sh_q  <= step_sh;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) res_q <= step_res;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode straight from registered state.
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;

endmodule
